countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Consumes the one-cycle enable pulses from the upstream clock-enable divider (one pulse per second at 27 MHz).
- Counts a loaded number of seconds down to zero and flags expiry.
- Drives the divider's sync input on each start, so the first second is a full second.
- Used by the alarm/FSM controller for delay, countdown and siren intervals.

Parameters:
- WIDTH, 4, width of the loaded value and of the remaining-count output.

Ports:
- clk  input  1  system clock (27 MHz).
- reset  input  1  asynchronous, active-low reset; state clears while reset==0.
- tick  input  1  one-cycle enable pulse from the upstream divider.
- start_timer  input  1  one-cycle request to load value and begin counting.
- value  input  WIDTH  number of ticks to count; sampled only on the start_timer cycle.
- divider_sync  output  1  one-cycle pulse to the upstream divider's sync input.
- busy  output  1  high while counting.
- remaining  output  WIDTH  current count.
- expired  output  1  expiry indication (pulse or level, see Optional Feature).

Behaviour:
- Reset (reset==0, asynchronous) forces the following; all outputs are registered.
  - state=IDLE, remaining=0, busy=0, expired=0, divider_sync=0.
- States:
  - IDLE: wait for start.
  - COUNT: decrement on tick.
  - DONE: one-cycle expiry state, then IDLE.
- IDLE, start_timer=1, value!=0:
  - Next cycle: remaining=value, busy=1, divider_sync=1 (exactly one cycle), state=COUNT.
- IDLE, start_timer=1, value==0:
  - Next cycle: state=DONE, expired=1, busy=0, divider_sync=1.
  - No ticks are required.
- COUNT, tick=1:
  - remaining>1: remaining decrements by 1.
  - remaining==1: remaining becomes 0, state=DONE, expired=1, busy=0, all on the next edge.
- COUNT, tick=0: hold.
- DONE: expired deasserts next cycle (pulse mode); state=IDLE.
- Restart at any state, including mid-count and in DONE:
  - start_timer=1 reloads value, reissues divider_sync, state=COUNT (or DONE if value==0).
  - Any pending expiry is cancelled.
- Simultaneous start_timer and tick: start wins; the tick is ignored; the count is not decremented.
- tick in IDLE or DONE: ignored.
- Latency from start to expired, for value=N>=1:
  - divider_sync restarts the divider's full period.
  - expired rises on the clock edge after the Nth tick following start.
- Arithmetic: unsigned WIDTH-bit; remaining never wraps below 0.
  - Max load is 2^WIDTH-1.
- divider_sync is never asserted except on the cycle following an accepted start_timer.
- Reset asserted mid-count: everything returns to reset values immediately, with no expired pulse.
  - After release, the block sits in IDLE until the next start.

Optional Feature:
- Macro: TIMER_EXPIRED_HOLD_EN.
- Defined: expired is a level.
  - Set on reaching zero; stays 1 in IDLE until the next accepted start_timer or reset.
  - It clears on the same edge that loads the new value.
  - busy behaviour is unchanged.
- Undefined (default): expired is a single-cycle pulse, as described in Behaviour.

Test Plan:
- Reset release, no inputs for 10 cycles -> all outputs 0, remaining=0.
- Start with value=3, tick pulse every 5 cycles:
  - cycle after start: divider_sync=1 for one cycle, remaining=3, busy=1.
  - remaining steps 2,1,0 on the edges after ticks 1,2,3.
  - expired high for exactly 1 cycle after tick 3; busy=0 on that same cycle.
- Start with value=0 -> expired=1 on the cycle after start, no tick needed, remaining=0, divider_sync=1.
- Start value=5, after 2 ticks assert start with value=2 on the same cycle as a tick:
  - remaining=2 (tick ignored), second divider_sync pulse.
  - expired only after 2 further ticks; no expiry from the first load.
- Start value=4, assert reset after 1 tick -> remaining=0, busy=0 asynchronously; expired never pulses.
  - After release, ticks cause no change.
- Compile with TIMER_EXPIRED_HOLD_EN, value=1, one tick:
  - expired stays 1 for 20+ cycles.
  - Next start with value=2 clears expired on its load edge.

Source files
------------

// File: rtl/countdown_timer.sv
// Seconds countdown timer driven by one-cycle tick pulses; resyncs the upstream divider on each start.
// Optional TIMER_EXPIRED_HOLD_EN: expired becomes a level held until the next start or reset.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] value,
    output logic             divider_sync,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             expired,
    output logic [1:0]       state_dbg
);

    // Handshake: start_timer and tick are single-cycle strobes with no ready;
    // a start is always accepted and overrides a coincident tick.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            remaining    <= '0;
            busy         <= 1'b0;
            expired      <= 1'b0;
            divider_sync <= 1'b0;
        end else begin
            divider_sync <= 1'b0;
            if (start_timer) begin
                divider_sync <= 1'b1;
                remaining    <= value;
                if (value == '0) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    expired <= 1'b1;
                end else begin
                    state   <= COUNT;
                    busy    <= 1'b1;
                    expired <= 1'b0;
                end
            end else begin
                case (state)
                    COUNT: begin
                        if (tick) begin
                            // remaining is never 0 here, so the decrement cannot wrap
                            if (remaining <= WIDTH'(1)) begin
                                remaining <= '0;
                                state     <= DONE;
                                busy      <= 1'b0;
                                expired   <= 1'b1;
                            end else begin
                                remaining <= remaining - WIDTH'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
`ifdef TIMER_EXPIRED_HOLD_EN
                        expired <= expired;
`else
                        expired <= 1'b0;
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
